// File: rtl/act_pingpong_buffer_if.sv
// Bundle of loader-side and array-side signals for act_pingpong_buffer.
// Strobes are accepted only in cycles where the matching status is high (wr_en/wr_done need wr_ready; rd_en/rd_release need rd_bank_valid); otherwise they are ignored.
interface act_pingpong_buffer_if #(
   parameter int NB_ROW = 8,
   parameter int CACT_W = 17,
   parameter int ADDR_W = 10
);
   logic                       wr_en;
   logic [NB_ROW-1:0]          wr_row_mask;
   logic [ADDR_W-1:0]          wr_addr;
   logic [NB_ROW*CACT_W-1:0]   wr_data;
   logic                       wr_done;
   logic                       wr_ready;
   logic                       rd_en;
   logic [ADDR_W-1:0]          rd_addr;
   logic                       rd_bcast;
   logic                       rd_release;
   logic                       rd_bank_valid;
   logic                       rd_valid;
   logic [NB_ROW*CACT_W-1:0]   rd_data;
   logic [1:0]                 full_cnt;
   logic                       oob_err;
   // Bank-ownership state, exposed for observation.
   logic                       dbg_wbank;
   logic                       dbg_rbank;
   logic [1:0]                 dbg_bank_st;

   modport master (
      output wr_en, wr_row_mask, wr_addr, wr_data, wr_done,
      output rd_en, rd_addr, rd_bcast, rd_release,
      input  wr_ready, rd_bank_valid, rd_valid, rd_data, full_cnt, oob_err,
      input  dbg_wbank, dbg_rbank, dbg_bank_st
   );

   modport slave (
      input  wr_en, wr_row_mask, wr_addr, wr_data, wr_done,
      input  rd_en, rd_addr, rd_bcast, rd_release,
      output wr_ready, rd_bank_valid, rd_valid, rd_data, full_cnt, oob_err,
      output dbg_wbank, dbg_rbank, dbg_bank_st
   );
endinterface

// File: rtl/act_pingpong_buffer.sv
// Double-buffered activation buffer: loader fills one bank while the PE array drains the other.
// Two-stage read pipeline (RAM read, output register) with row broadcast and out-of-range flagging.
module act_pingpong_buffer #(
   parameter int NB_ROW = 8,
   parameter int ACT_W  = 16,
   parameter int CACT_W = ACT_W + 1,
   parameter int DEPTH  = 768,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   act_pingpong_buffer_if.slave   bus
);

   localparam logic [0:0] ST_FREE = 1'b0;
   localparam logic [0:0] ST_FULL = 1'b1;

   logic                 r_wbank;
   logic                 r_rbank;
   logic [1:0]           r_bank_st;
   logic                 r_oob_err;

   logic                 r_s1_valid;
   logic                 r_s1_bcast;
   logic                 r_s1_oob;
   logic [CACT_W-1:0]    r_s1_word [NB_ROW];

   logic                 r_rd_valid;
   logic [NB_ROW*CACT_W-1:0] r_rd_data;

   logic [CACT_W-1:0]    r_mem [2][NB_ROW][DEPTH];

   logic                 w_wr_ready;
   logic                 w_rd_bank_valid;
   logic                 w_wr_oob;
   logic                 w_rd_oob;
   logic                 w_wr_take;
   logic                 w_rd_take;
   logic                 w_done;
   logic                 w_rel;
   logic [NB_ROW*CACT_W-1:0] w_out;

   assign w_wr_ready      = (r_bank_st[r_wbank] == ST_FREE);
   assign w_rd_bank_valid = (r_bank_st[r_rbank] == ST_FULL);
   assign w_wr_oob        = (32'(bus.wr_addr) >= DEPTH);
   assign w_rd_oob        = (32'(bus.rd_addr) >= DEPTH);
   assign w_wr_take       = bus.wr_en & w_wr_ready & ~w_wr_oob;
   assign w_rd_take       = bus.rd_en & w_rd_bank_valid;
   assign w_done          = bus.wr_done & w_wr_ready;
   assign w_rel           = bus.rd_release & w_rd_bank_valid;

   // wr_ready implies wbank is FREE and rd_bank_valid implies rbank is FULL,
   // so a simultaneous done/release always touches two different banks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wbank   <= 1'b0;
         r_rbank   <= 1'b0;
         r_bank_st <= {ST_FREE, ST_FREE};
         r_oob_err <= 1'b0;
      end else begin
         if (w_done) r_bank_st[r_wbank] <= ST_FULL;
         if (w_rel)  r_bank_st[r_rbank] <= ST_FREE;
         r_wbank <= r_wbank ^ w_done;
         r_rbank <= r_rbank ^ w_rel;
         if ((bus.wr_en && w_wr_ready && w_wr_oob) || (w_rd_take && w_rd_oob))
            r_oob_err <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NB_ROW; i++) begin
         if (w_wr_take && bus.wr_row_mask[i])
            r_mem[r_wbank][i][bus.wr_addr] <= bus.wr_data[(i+1)*CACT_W-1 -: CACT_W];
      end
   end

   always_ff @(posedge clk) begin
      if (w_rd_take && !w_rd_oob) begin
         for (int i = 0; i < NB_ROW; i++)
            r_s1_word[i] <= r_mem[r_rbank][i][bus.rd_addr];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_bcast <= 1'b0;
         r_s1_oob   <= 1'b0;
      end else begin
         r_s1_valid <= w_rd_take;
         if (w_rd_take) begin
            r_s1_bcast <= bus.rd_bcast;
            r_s1_oob   <= w_rd_oob;
         end
      end
   end

   always_comb begin
      w_out = '0;
      for (int i = 0; i < NB_ROW; i++) begin
         if (r_s1_oob)
            w_out[(i+1)*CACT_W-1 -: CACT_W] = '0;
         else if (r_s1_bcast)
            w_out[(i+1)*CACT_W-1 -: CACT_W] = r_s1_word[0];
         else
            w_out[(i+1)*CACT_W-1 -: CACT_W] = r_s1_word[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
      end else begin
         r_rd_valid <= r_s1_valid;
         if (r_s1_valid) r_rd_data <= w_out;
      end
   end

   assign bus.wr_ready      = w_wr_ready;
   assign bus.rd_bank_valid = w_rd_bank_valid;
   assign bus.rd_valid      = r_rd_valid;
   assign bus.rd_data       = r_rd_data;
   assign bus.full_cnt      = {1'b0, r_bank_st[0]} + {1'b0, r_bank_st[1]};
   assign bus.oob_err       = r_oob_err;
   assign bus.dbg_wbank     = r_wbank;
   assign bus.dbg_rbank     = r_rbank;
   assign bus.dbg_bank_st   = r_bank_st;

endmodule

// File: tb/tb_act_pingpong_buffer.sv
// Directed bench for act_pingpong_buffer: fill/drain, ping-pong overlap, both-full,
// row mask and broadcast, out-of-range, and reset during a read.
module tb_act_pingpong_buffer;

   localparam int NB_ROW = 8;
   localparam int CACT_W = 17;
   localparam int ADDR_W = 10;
   localparam int DW     = NB_ROW * CACT_W;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   act_pingpong_buffer_if #(.NB_ROW(NB_ROW), .CACT_W(CACT_W), .ADDR_W(ADDR_W)) bus ();

   act_pingpong_buffer #(.NB_ROW(NB_ROW), .ACT_W(16), .CACT_W(CACT_W), .DEPTH(768), .ADDR_W(ADDR_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] pat(input logic [15:0] base, input int a);
      logic [DW-1:0] v;
      v = '0;
      for (int i = 0; i < NB_ROW; i++)
         v[(i+1)*CACT_W-1 -: CACT_W] = {1'b0, 16'(base + 16'(a*16) + 16'(i))};
      return v;
   endfunction

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v, input logic [DW-1:0] new_v,
                                           input logic [NB_ROW-1:0] m);
      logic [DW-1:0] v;
      v = old_v;
      for (int i = 0; i < NB_ROW; i++)
         if (m[i]) v[(i+1)*CACT_W-1 -: CACT_W] = new_v[(i+1)*CACT_W-1 -: CACT_W];
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_s(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic write_word(input int a, input logic [DW-1:0] d, input logic [NB_ROW-1:0] m);
      bus.wr_en = 1'b1; bus.wr_addr = ADDR_W'(a); bus.wr_data = d; bus.wr_row_mask = m;
      tick();
      bus.wr_en = 1'b0; bus.wr_row_mask = '0;
   endtask

   task automatic fill(input logic [15:0] base, input int n);
      for (int k = 0; k < n; k++) write_word(k, pat(base, k), 8'hFF);
   endtask

   task automatic pulse(input logic done, input logic rel);
      bus.wr_done = done; bus.rd_release = rel;
      tick();
      bus.wr_done = 1'b0; bus.rd_release = 1'b0;
   endtask

   // Back-to-back reads of addresses 0..n-1; each word appears two edges after its rd_en.
   task automatic read_stream(input string tag, input logic [15:0] base, input int n);
      for (int k = 0; k <= n; k++) begin
         if (k < n) begin bus.rd_en = 1'b1; bus.rd_addr = ADDR_W'(k); end
         else bus.rd_en = 1'b0;
         tick();
         if (k == 0) chk_s({tag, "_lat"}, 8'(bus.rd_valid), 8'd0);
         else begin
            chk_s({tag, "_valid"}, 8'(bus.rd_valid), 8'd1);
            chk({tag, "_data"}, bus.rd_data, pat(base, k-1));
         end
      end
   endtask

   task automatic read_one(input string tag, input int a, input logic bc, input logic [DW-1:0] exp);
      bus.rd_en = 1'b1; bus.rd_addr = ADDR_W'(a); bus.rd_bcast = bc;
      tick();
      bus.rd_en = 1'b0; bus.rd_bcast = 1'b0;
      chk_s({tag, "_lat"}, 8'(bus.rd_valid), 8'd0);
      tick();
      chk_s({tag, "_valid"}, 8'(bus.rd_valid), 8'd1);
      chk({tag, "_data"}, bus.rd_data, exp);
      tick();
      chk_s({tag, "_vdrop"}, 8'(bus.rd_valid), 8'd0);
      chk({tag, "_hold"}, bus.rd_data, exp);
   endtask

   initial begin
      logic [DW-1:0] bc_exp;
      total = 0; bad = 0;
      rst_n = 1'b0;
      bus.wr_en = 1'b0; bus.wr_row_mask = '0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_done = 1'b0;
      bus.rd_en = 1'b0; bus.rd_addr = '0; bus.rd_bcast = 1'b0; bus.rd_release = 1'b0;
      repeat (3) tick();
      chk_s("rst_rd_valid", 8'(bus.rd_valid), 8'd0);
      chk("rst_rd_data", bus.rd_data, '0);
      chk_s("rst_oob", 8'(bus.oob_err), 8'd0);
      chk_s("rst_full_cnt", 8'(bus.full_cnt), 8'd0);
      chk_s("rst_wr_ready", 8'(bus.wr_ready), 8'd1);
      chk_s("rst_rbv", 8'(bus.rd_bank_valid), 8'd0);
      rst_n = 1'b1;
      tick();

      // Fill and drain bank 0
      fill(16'h0100, 4);
      pulse(1'b1, 1'b0);
      chk_s("t1_full_cnt", 8'(bus.full_cnt), 8'd1);
      chk_s("t1_rbv", 8'(bus.rd_bank_valid), 8'd1);
      chk_s("t1_wr_ready", 8'(bus.wr_ready), 8'd1);
      read_stream("t1_rd", 16'h0100, 4);
      pulse(1'b0, 1'b1);
      chk_s("t1_full_after_rel", 8'(bus.full_cnt), 8'd0);
      chk_s("t1_rbv_after_rel", 8'(bus.rd_bank_valid), 8'd0);

      // Ping-pong: fill bank 1, then refill bank 0 while draining bank 1
      fill(16'h0200, 4);
      pulse(1'b1, 1'b0);
      chk_s("t2_full_cnt", 8'(bus.full_cnt), 8'd1);
      for (int k = 0; k <= 4; k++) begin
         if (k < 4) begin
            bus.wr_en = 1'b1; bus.wr_addr = ADDR_W'(k); bus.wr_data = pat(16'h0300, k); bus.wr_row_mask = 8'hFF;
            bus.rd_en = 1'b1; bus.rd_addr = ADDR_W'(k);
         end else begin
            bus.wr_en = 1'b0; bus.rd_en = 1'b0;
         end
         tick();
         if (k > 0) chk("t2_overlap_data", bus.rd_data, pat(16'h0200, k-1));
      end
      bus.wr_row_mask = '0;
      pulse(1'b1, 1'b1);
      chk_s("t2_full_same", 8'(bus.full_cnt), 8'd1);
      chk_s("t2_rbank", 8'(bus.dbg_rbank), 8'd0);
      chk_s("t2_rbv", 8'(bus.rd_bank_valid), 8'd1);
      read_stream("t2_rd", 16'h0300, 4);

      // Both banks full: writes and wr_done are ignored
      pulse(1'b1, 1'b0);
      chk_s("t3_full_cnt", 8'(bus.full_cnt), 8'd2);
      chk_s("t3_wr_ready", 8'(bus.wr_ready), 8'd0);
      write_word(0, {DW{1'b1}}, 8'hFF);
      pulse(1'b1, 1'b0);
      chk_s("t3_full_still2", 8'(bus.full_cnt), 8'd2);
      read_one("t3_rd_b0", 0, 1'b0, pat(16'h0300, 0));
      pulse(1'b0, 1'b1);
      chk_s("t3_full_after_rel", 8'(bus.full_cnt), 8'd1);
      chk_s("t3_wr_ready_after_rel", 8'(bus.wr_ready), 8'd1);
      read_one("t3_rd_b1", 0, 1'b0, pat(16'h0200, 0));

      // Row mask and broadcast on bank 0, addr 5
      write_word(5, pat(16'h0400, 5), 8'hFF);
      write_word(5, pat(16'h0500, 5), 8'b0000_0101);
      pulse(1'b1, 1'b0);
      chk_s("t4_full_cnt", 8'(bus.full_cnt), 8'd2);
      pulse(1'b0, 1'b1);
      read_one("t4_mask", 5, 1'b0, merge(pat(16'h0400, 5), pat(16'h0500, 5), 8'b0000_0101));
      for (int i = 0; i < NB_ROW; i++) bc_exp[(i+1)*CACT_W-1 -: CACT_W] = 17'h00550;
      read_one("t4_bcast", 5, 1'b1, bc_exp);

      // Out of range and illegal reads
      chk_s("t5_oob_before", 8'(bus.oob_err), 8'd0);
      write_word(768, pat(16'h0700, 0), 8'hFF);
      chk_s("t5_oob_wr", 8'(bus.oob_err), 8'd1);
      chk_s("t5_full_unchanged", 8'(bus.full_cnt), 8'd1);
      read_one("t5_oob_rd", 800, 1'b0, '0);
      chk_s("t5_oob_sticky", 8'(bus.oob_err), 8'd1);
      pulse(1'b0, 1'b1);
      chk_s("t5_full0", 8'(bus.full_cnt), 8'd0);
      chk_s("t5_rbv0", 8'(bus.rd_bank_valid), 8'd0);
      bus.rd_en = 1'b1; bus.rd_addr = '0;
      tick();
      bus.rd_en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk_s("t5_illegal_rd", 8'(bus.rd_valid), 8'd0);
         tick();
      end
      chk_s("t5_oob_still", 8'(bus.oob_err), 8'd1);

      // Reset one cycle after an accepted read
      write_word(0, pat(16'h0600, 0), 8'hFF);
      pulse(1'b1, 1'b0);
      chk_s("t6_rbv", 8'(bus.rd_bank_valid), 8'd1);
      bus.rd_en = 1'b1; bus.rd_addr = '0;
      tick();
      bus.rd_en = 1'b0;
      rst_n = 1'b0;
      #1;
      chk_s("t6_rd_valid", 8'(bus.rd_valid), 8'd0);
      chk_s("t6_full_cnt", 8'(bus.full_cnt), 8'd0);
      chk_s("t6_wr_ready", 8'(bus.wr_ready), 8'd1);
      chk_s("t6_rbv0", 8'(bus.rd_bank_valid), 8'd0);
      chk_s("t6_oob_clr", 8'(bus.oob_err), 8'd0);
      tick();
      chk_s("t6_rd_valid_later", 8'(bus.rd_valid), 8'd0);
      rst_n = 1'b1;
      tick();
      chk_s("t6_rd_valid_post", 8'(bus.rd_valid), 8'd0);
      chk("t6_rd_data_post", bus.rd_data, '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
